des_key_sched: RTL and testbench
================================

# des_key_sched

Sequential DES key-schedule generator that turns one 64-bit key into the sixteen 48-bit round subkeys, one per handshake beat. It runs in either direction: K1..K16 for encryption (left rotations) or K16..K1 for decryption (right rotations). It sits between the key register and the Feistel round datapath. It reuses the existing `PC1` module for the initial permutation and holds an internal PC-2 permutation.

## Interface

- No parameters; all widths fixed by FIPS 46-3.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `key` input [1:64]: DES key, bit 1 = MSB (FIPS numbering); parity bits 8,16,…,64 are ignored by PC-1.
- `decrypt` input 1: 0 = emit K1→K16, 1 = emit K16→K1; sampled only on accepted `start`.
- `start` input 1: request new schedule; accepted only when `busy`=0.
- `subkey` output [1:48]: current round subkey, PC-2 of registered C/D halves.
- `subkey_valid` output 1: `subkey` and `round` are valid.
- `subkey_ready` input 1: consumer accepts the subkey on a cycle where `subkey_valid`=1.
- `round` output [3:0]: 0-based index of the emitted subkey in emission order (0..15).
- `busy` output 1: schedule in progress; `start` is ignored.
- `done` output 1: one-cycle pulse after the 16th subkey is accepted.

## Operation

- State: `IDLE`, `RUN`. Registers: C[1:28], D[1:28], `round`, `mode`.
- Shift table (encrypt round r=1..16): 1 for r ∈ {1,2,9,16}, else 2. Cumulative total is 28.
- Accepted `start` in `IDLE`:
  - (C,D) ← PC1(`key`) split into C = bits 1–28 and D = bits 29–56.
  - Encrypt: rotate both halves left by 1, giving C1/D1.
  - Decrypt: no rotation, since C16/D16 = C0/D0.
  - `mode` ← `decrypt`, `round` ← 0, go to `RUN`.
- `RUN`:
  - `subkey_valid`=1 and `subkey` = PC2(C‖D).
  - On each `subkey_valid && subkey_ready` with `round`<15, `round`+1 and the halves rotate:
    - Encrypt: left by shift(`round`+2).
    - Decrypt: right by shift(16−`round`).
  - Resulting decrypt right-shift sequence after beats 1..15: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Acceptance at `round`=15: go to `IDLE`, drop `subkey_valid`, pulse `done`; C/D are don't-care afterwards.
- While `subkey_ready`=0: C, D, `round` and `subkey` hold stable and `subkey_valid` stays 1 (no retraction).
- `start` while `busy`=1: ignored, with no effect on state or mode.
- `key`/`decrypt` changing mid-schedule: no effect; only the values sampled at `start` are used.
- Rotations are within 28 bits and wrap; C and D are never mixed.

## Timing

- Reset (async assert, sync release): state `IDLE`, C=D=0, `round`=0, `subkey_valid`=0, `busy`=0, `done`=0. `subkey` then reads PC2(0)=0.
- Reset asserted mid-schedule: immediate return to reset values. The partial schedule is discarded and no `done` is produced.
- `start` sampled at edge N: `busy`=1 and `subkey_valid`=1 from edge N (visible in cycle N+1). First-subkey latency is 1 cycle.
- With `subkey_ready` held high: 16 consecutive subkey beats (cycles N+1..N+16), `done`=1 in cycle N+17, `busy`=0 in cycle N+17.
- `start` in the same cycle `done`=1: accepted, so back-to-back schedules are allowed with a 1-cycle gap.
- `busy` = (state == `RUN`); `done` is registered and never coincides with `subkey_valid`=1 of the same schedule.

## Test plan

- Reset, then key=133457799BBCDFF1, `decrypt`=0, `start`, `subkey_ready`=1 → round 0 subkey = 1B02EFFC7072, round 15 subkey = CB3D8B0E17F5, `done` pulses in cycle N+17.
- Same key, `decrypt`=1 → round 0 subkey = CB3D8B0E17F5, round 15 = 1B02EFFC7072. All 16 values equal the encrypt sequence reversed.
- Random `subkey_ready` backpressure (≈50%) → `subkey`/`round` stable while stalled, exactly 16 accepted beats, sequence identical to the no-stall run.
- `start` with a different key and `decrypt` pulsed during `RUN` → ignored; the sequence is unchanged. Then `start` on the `done` cycle → new schedule begins next cycle.
- `rst_n` low at round 7 → all outputs go to reset values asynchronously. A new `start` after release → a full correct 16-beat schedule.
- Key 0101010101010101 (weak key) → all 16 subkeys = 000000000000 in both modes.

Source files
------------

// File: rtl/des_key_sched.sv
// DES key schedule: PC-1 permutation plus a sequential round-subkey generator.
// Keys use FIPS bit numbering (bit 1 = MSB) throughout.

// PC-1: selects the 56 non-parity key bits, giving C0 (bits 1-28) and D0 (bits 29-56).
module des_pc1 (
  input  logic [1:64] key_in,
  output logic [1:56] pc1_out
);

  // Parity bits take no part in the schedule.
  logic parity_unused;

  // Fixed bit selection.
  assign pc1_out = {
    key_in[57], key_in[49], key_in[41], key_in[33], key_in[25], key_in[17], key_in[9],
    key_in[1],  key_in[58], key_in[50], key_in[42], key_in[34], key_in[26], key_in[18],
    key_in[10], key_in[2],  key_in[59], key_in[51], key_in[43], key_in[35], key_in[27],
    key_in[19], key_in[11], key_in[3],  key_in[60], key_in[52], key_in[44], key_in[36],
    key_in[63], key_in[55], key_in[47], key_in[39], key_in[31], key_in[23], key_in[15],
    key_in[7],  key_in[62], key_in[54], key_in[46], key_in[38], key_in[30], key_in[22],
    key_in[14], key_in[6],  key_in[61], key_in[53], key_in[45], key_in[37], key_in[29],
    key_in[21], key_in[13], key_in[5],  key_in[28], key_in[20], key_in[12], key_in[4]
  };

  assign parity_unused = ^{key_in[8],  key_in[16], key_in[24], key_in[32],
                           key_in[40], key_in[48], key_in[56], key_in[64]};

endmodule

// Round subkey generator with valid/ready output handshake.
//
// state | meaning
// IDLE  | no schedule in progress; waits for start
// RUN   | subkey for round_q is presented; advances on each accepted beat
module des_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:64] key,
  input  logic        decrypt,
  input  logic        start,
  output logic [1:48] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:28] c_q, c_d;
  logic [1:28] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic [1:56] pc1_key;
  logic [4:0]  shift_idx;
  logic        shift_two;

  // 28-bit wraparound rotation by one or two places; "left" moves bits toward bit 1.
  function automatic logic [1:28] rot28(input logic [1:28] x, input logic dir_right,
                                        input logic by_two);
    logic [1:28] r;
    if (!dir_right) r = by_two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    else            r = by_two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    return r;
  endfunction

  des_pc1 u_pc1 (
    .key_in (key),
    .pc1_out(pc1_key)
  );

  // Encrypt round r rotates by shift(r); the decrypt walk undoes rounds 16 down to 2.
  always_comb begin
    shift_idx = mode_q ? (5'd16 - {1'b0, round_q}) : ({1'b0, round_q} + 5'd2);
    shift_two = !((shift_idx == 5'd1) || (shift_idx == 5'd2) ||
                  (shift_idx == 5'd9) || (shift_idx == 5'd16));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Decrypt starts from C16/D16, which equal C0/D0 after a full 28-place turn.
          c_d     = decrypt ? pc1_key[1:28]  : rot28(pc1_key[1:28], 1'b0, 1'b0);
          d_d     = decrypt ? pc1_key[29:56] : rot28(pc1_key[29:56], 1'b0, 1'b0);
          mode_d  = decrypt;
          round_d = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
            round_d = 4'd0;
          end else begin
            round_d = round_q + 4'd1;
            c_d     = rot28(c_q, mode_q, shift_two);
            d_d     = rot28(d_q, mode_q, shift_two);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= 4'd0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // PC-2 over C||D: positions 1-28 come from C, 29-56 from D.
  assign subkey = {
    c_q[14], c_q[17], c_q[11], c_q[24], c_q[1],  c_q[5],
    c_q[3],  c_q[28], c_q[15], c_q[6],  c_q[21], c_q[10],
    c_q[23], c_q[19], c_q[12], c_q[4],  c_q[26], c_q[8],
    c_q[16], c_q[7],  c_q[27], c_q[20], c_q[13], c_q[2],
    d_q[13], d_q[24], d_q[3],  d_q[9],  d_q[19], d_q[27],
    d_q[2],  d_q[12], d_q[23], d_q[17], d_q[5],  d_q[20],
    d_q[16], d_q[21], d_q[11], d_q[28], d_q[6],  d_q[25],
    d_q[18], d_q[14], d_q[22], d_q[8],  d_q[1],  d_q[4]
  };

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign round        = round_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: stimulus pushes expected subkeys, a
// negedge monitor pops and compares on every accepted beat.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic        start = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  bit ready_rand = 1'b0;

  logic [47:0] exp_sk[$];
  logic [3:0]  exp_rnd[$];
  bit          done_exp = 1'b0;
  bit          done_nxt;
  bit          prev_stall = 1'b0;
  logic [47:0] prev_sk;
  logic [3:0]  prev_rnd;
  logic [47:0] pop_sk;
  logic [3:0]  pop_rnd;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  des_key_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .decrypt     (decrypt),
    .start       (start),
    .subkey      (subkey),
    .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready),
    .round       (round),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rotl28(input logic [63:0] x, input int s);
    if (s == 0) return x;
    return ((x << s) | (x >> (28 - s))) & 64'hFFF_FFFF;
  endfunction

  // Reference: Kr = PC2(rotl(C0, cum(r)) || rotl(D0, cum(r))); decrypt emits the list reversed.
  task automatic push_expected(input logic [63:0] k, input bit dec);
    logic [47:0] ks [16];
    logic [63:0] c0, d0, c, d, cd, sk;
    int cum;
    c0 = '0; d0 = '0; cum = 0;
    for (int i = 0; i < 28; i++) c0 = (c0 << 1) | ((k >> (64 - PC1_T[i])) & 64'd1);
    for (int i = 28; i < 56; i++) d0 = (d0 << 1) | ((k >> (64 - PC1_T[i])) & 64'd1);
    for (int r = 0; r < 16; r++) begin
      cum += SHIFTS[r];
      c  = rotl28(c0, cum % 28);
      d  = rotl28(d0, cum % 28);
      cd = (c << 28) | d;
      sk = '0;
      for (int j = 0; j < 48; j++) sk = (sk << 1) | ((cd >> (56 - PC2_T[j])) & 64'd1);
      ks[r] = sk[47:0];
    end
    for (int i = 0; i < 16; i++) begin
      exp_sk.push_back(dec ? ks[15 - i] : ks[i]);
      exp_rnd.push_back(4'(i));
    end
  endtask

  // Consumer: always ready, or a coin flip each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1 subkey_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_exp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done", done, done_exp);
      chk("busy_vs_valid", busy, subkey_valid);
      if (done) chk("valid_during_done", subkey_valid, 1'b0);
      if (prev_stall) begin
        chk("stall_valid", subkey_valid, 1'b1);
        chk("stall_subkey", subkey, prev_sk);
        chk("stall_round", round, prev_rnd);
      end
      done_nxt = 1'b0;
      if (subkey_valid && subkey_ready) begin
        if (exp_sk.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: actual round %0d subkey %h, required no beat", round, subkey);
        end else begin
          pop_sk  = exp_sk.pop_front();
          pop_rnd = exp_rnd.pop_front();
          chk("subkey", subkey, pop_sk);
          chk("round", round, pop_rnd);
          if (pop_rnd == 4'd15) done_nxt = 1'b1;
        end
      end
      prev_stall = subkey_valid && !subkey_ready;
      prev_sk    = subkey;
      prev_rnd   = round;
      done_exp   = done_nxt;
    end
  end

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 200) begin
      n_cmp++; n_err++;
      $display("FAIL %s: busy still 1, required 0 within 200 cycles", name);
    end
  endtask

  task automatic wait_done(input string name, output bit ok);
    int i;
    ok = 1'b0;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL %s: done never seen, required within 2000 cycles", name);
    end
  endtask

  // Cycle-exact schedule with the consumer always ready.
  task automatic sched_fixed(input logic [63:0] k, input bit dec,
                             input logic [47:0] first, input logic [47:0] last);
    @(posedge clk);
    #1 key = k; decrypt = dec; start = 1'b1;
    push_expected(k, dec);
    @(posedge clk);
    #1 start = 1'b0; key = ~k; decrypt = ~dec;
    @(negedge clk);
    chk("lat_valid", subkey_valid, 1'b1);
    chk("lat_busy", busy, 1'b1);
    chk("first_subkey", subkey, first);
    chk("first_round", round, 4'd0);
    repeat (15) @(negedge clk);
    chk("last_subkey", subkey, last);
    chk("last_round", round, 4'd15);
    @(negedge clk);
    chk("done_at_n17", done, 1'b1);
    chk("busy_at_n17", busy, 1'b0);
  endtask

  task automatic rand_sched(input logic [63:0] k, input bit dec);
    bit ok;
    wait_idle("rand_idle");
    @(posedge clk);
    #1 key = k; decrypt = dec; start = 1'b1;
    push_expected(k, dec);
    @(posedge clk);
    #1 start = 1'b0; key = {$urandom, $urandom}; decrypt = 1'($urandom_range(0, 1));
    wait_done("rand_done", ok);
  endtask

  initial begin
    bit ok;
    logic [63:0] k;
    int i;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", subkey_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_round", round, 4'd0);
    chk("rst_subkey", subkey, 48'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Known-answer vectors and weak key, both directions.
    sched_fixed(64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
    sched_fixed(64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072);
    sched_fixed(64'h0101010101010101, 1'b0, 48'h0, 48'h0);
    sched_fixed(64'h0101010101010101, 1'b1, 48'h0, 48'h0);

    // Backpressure with random keys and directions.
    ready_rand = 1'b1;
    rand_sched(64'h133457799BBCDFF1, 1'b0);
    rand_sched(64'h133457799BBCDFF1, 1'b1);
    repeat (6) rand_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)));

    // start during RUN is ignored; start on the done cycle is accepted.
    wait_idle("t4_idle");
    k = {$urandom, $urandom};
    @(posedge clk);
    #1 key = k; decrypt = 1'b0; start = 1'b1;
    push_expected(k, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 key = ~k; decrypt = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t4_first_done", ok);
    if (ok) begin
      k = {$urandom, $urandom};
      key = k; decrypt = 1'b1; start = 1'b1;
      push_expected(k, 1'b1);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("b2b_valid", subkey_valid, 1'b1);
      chk("b2b_round", round, 4'd0);
      wait_done("t4_second_done", ok);
    end

    // Asynchronous reset in the middle of a schedule.
    ready_rand = 1'b0;
    wait_idle("t5_idle");
    @(posedge clk);
    #1 key = {$urandom, $urandom}; decrypt = 1'b0; start = 1'b1;
    push_expected(key, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (subkey_valid && round == 4'd7) break;
    end
    if (i == 100) begin
      n_cmp++; n_err++;
      $display("FAIL t5_round7: round 7 never presented, required within 100 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", subkey_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_round", round, 4'd0);
    chk("arst_subkey", subkey, 48'h0);
    exp_sk.delete();
    exp_rnd.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 1'b0);
    end
    ready_rand = 1'b1;
    rand_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)));
    rand_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)));

    ready_rand = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_sk.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
